// File: rtl/fnd_scan_ctrl.sv
// ============================================================================
// fnd_scan_ctrl
// ----------------------------------------------------------------------------
// Four-digit 7-segment scan controller for the up-counter display path.
// Once per frame the binary counter value is saturated to 9999 and turned
// into BCD by a sequential double-dabble engine. One digit is driven per scan
// period. A frame that starts at boundary k shows the value sampled at
// boundary k-1, so a frame never mixes digits of two different values.
//
// Parameters:
//   ACTIVE_LOW   1 = com/font outputs active-low (common-anode board),
//                0 = both outputs inverted to active-high
//
// Ports:
//   i_clk        system clock (100 MHz)
//   i_reset      asynchronous, active-high reset
//   i_scan_clk   divided digit clock; sampled as data, never used as a clock
//   i_value      14-bit binary value to display (saturates at 9999)
//   o_fnd_com    one-hot digit enables, bit 0 = ones, bit 3 = thousands
//   o_fnd_font   segments {dp,g,f,e,d,c,b,a}, dp always off
//   o_busy       high while a BCD conversion is running
//
// Build option:
//   FND_LZ_BLANK_EN  when defined, leading zeros in the thousands, hundreds
//                    and tens positions are blanked; the ones digit always
//                    shows its numeral.
// ============================================================================
module fnd_scan_ctrl #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_scan_clk,
    input  logic [13:0] i_value,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font,
    output logic        o_busy
);

    // XOR masks that turn the internal active-low patterns into the board
    // polarity.
    localparam logic [3:0] COM_INV  = ACTIVE_LOW ? 4'h0  : 4'hF;
    localparam logic [7:0] FONT_INV = ACTIVE_LOW ? 8'h00 : 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic        s0;
    logic        s1;
    logic        p;
    logic        tick;
    logic        frame;
    logic [1:0]  r_digit;
    logic [1:0]  next_digit;
    logic [15:0] r_disp;
    logic [15:0] r_bcd;
    logic [29:0] sr;
    logic [29:0] sr_adj;
    logic [3:0]  cnt;
    logic [13:0] sat_value;
    logic [15:0] src;
    logic [3:0]  nibble;
    logic        blank;
    logic [3:0]  com_al;
    logic [7:0]  font_al;

    // Active-low segment pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    assign tick       = s1 & ~p;
    assign frame      = tick && (r_digit == 2'd3);
    assign next_digit = r_digit + 2'd1;
    assign sat_value  = (i_value > 14'd9999) ? 14'd9999 : i_value;
    assign o_busy     = (state != IDLE);

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decimal place.
    always_comb begin
        sr_adj = sr;
        for (int k = 0; k < 4; k++) begin
            if (sr[14 + 4*k +: 4] >= 4'd5) begin
                sr_adj[14 + 4*k +: 4] = sr[14 + 4*k +: 4] + 4'd3;
            end
        end
    end

    // At a frame boundary r_disp is being overwritten in the same edge, so
    // the new digit reads straight from r_bcd.
    always_comb begin
        src     = frame ? r_bcd : r_disp;
        nibble  = src[{next_digit, 2'b00} +: 4];
        blank   = 1'b0;
`ifdef FND_LZ_BLANK_EN
        case (next_digit)
            2'd1:    blank = (src[15:4]  == 12'd0);
            2'd2:    blank = (src[15:8]  == 8'd0);
            2'd3:    blank = (src[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        font_al = blank ? 8'hFF : seg_of(nibble);
        com_al  = ~(4'b0001 << next_digit);
    end

    // Scan-clock synchronizer and edge detect, scan index, frame-coherent
    // display copy and the registered digit/segment outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s0         <= 1'b0;
            s1         <= 1'b0;
            p          <= 1'b0;
            r_digit    <= 2'd3;
            r_disp     <= 16'd0;
            o_fnd_com  <= 4'hF ^ COM_INV;
            o_fnd_font <= 8'hFF ^ FONT_INV;
        end else begin
            s0 <= i_scan_clk;
            s1 <= s0;
            p  <= s1;
            if (tick) begin
                r_digit    <= next_digit;
                o_fnd_com  <= com_al ^ COM_INV;
                o_fnd_font <= font_al ^ FONT_INV;
            end
            if (frame) begin
                r_disp <= r_bcd;
            end
        end
    end

    // Conversion FSM: latch the saturated value at a frame boundary, run 14
    // correct-and-shift steps, then publish the BCD result. Boundaries that
    // arrive mid-conversion do not restart it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            sr    <= 30'd0;
            cnt   <= 4'd0;
            r_bcd <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame) begin
                        sr    <= {16'd0, sat_value};
                        cnt   <= 4'd0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd13) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd <= sr[29:14];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// ============================================================================
// tb_fnd_scan_ctrl
// ----------------------------------------------------------------------------
// Directed bench for fnd_scan_ctrl. Drives i_scan_clk pulses slow enough for
// a full conversion between ticks and compares the digit enables, segment
// patterns and busy length against hand-computed values.
// ============================================================================
module tb_fnd_scan_ctrl;

    logic        i_clk;
    logic        i_reset;
    logic        i_scan_clk;
    logic [13:0] i_value;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_font;
    logic        o_busy;

    int checks;
    int errors;

    // Font shown for a leading-zero position (tens/hundreds/thousands).
`ifdef FND_LZ_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    fnd_scan_ctrl #(.ACTIVE_LOW(1'b1)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_scan_clk (i_scan_clk),
        .i_value    (i_value),
        .o_fnd_com  (o_fnd_com),
        .o_fnd_font (o_fnd_font),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One scan period: 4 cycles high, 20 low, counting cycles with o_busy.
    task automatic applyStimulus(output int busyCount);
        busyCount = 0;
        @(negedge i_clk);
        i_scan_clk = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge i_clk);
            if (o_busy) busyCount++;
            if (i == 3) i_scan_clk = 1'b0;
        end
    endtask

    // A full frame (digits 0..3); every digit's com/font is compared and the
    // boundary tick must give exactly 15 busy cycles.
    task automatic runFrame(input string tag, input logic [7:0] f0,
                            input logic [7:0] f1, input logic [7:0] f2,
                            input logic [7:0] f3);
        int bc;
        logic [7:0] fonts [4];
        fonts[0] = f0; fonts[1] = f1; fonts[2] = f2; fonts[3] = f3;
        for (int d = 0; d < 4; d++) begin
            applyStimulus(bc);
            checkOutput($sformatf("%s_com%0d", tag, d), {12'd0, o_fnd_com},
                        {12'd0, ~(4'b0001 << d)});
            checkOutput($sformatf("%s_font%0d", tag, d), {8'd0, o_fnd_font},
                        {8'd0, fonts[d]});
            checkOutput($sformatf("%s_busy%0d", tag, d), 16'(bc),
                        (d == 0) ? 16'd15 : 16'd0);
        end
    endtask

    initial begin
        int  bc;
        bit  seen;
        checks     = 0;
        errors     = 0;
        i_reset    = 1'b1;
        i_scan_clk = 1'b0;
        i_value    = 14'd0;

        // Reset state
        repeat (5) @(negedge i_clk);
        checkOutput("rst_com",  {12'd0, o_fnd_com},  16'h000F);
        checkOutput("rst_font", {8'd0, o_fnd_font},  16'h00FF);
        checkOutput("rst_busy", {15'd0, o_busy},     16'h0000);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);

        // Normal display: first frame shows reset r_bcd, second shows 1234
        i_value = 14'd1234;
        runFrame("n1234a", 8'hC0, LZ, LZ, LZ);
        runFrame("n1234b", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Saturation
        i_value = 14'd16383;
        runFrame("sat_a", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        runFrame("sat_b", 8'h90, 8'h90, 8'h90, 8'h90);

        // Leading zeros
        i_value = 14'd7;
        runFrame("v7a", 8'h90, 8'h90, 8'h90, 8'h90);
        runFrame("v7b", 8'hF8, LZ, LZ, LZ);
        i_value = 14'd0;
        runFrame("v0a", 8'hF8, LZ, LZ, LZ);
        runFrame("v0b", 8'hC0, LZ, LZ, LZ);

        // Edge detect and frame coherence
        i_value = 14'd1111;
        runFrame("c1a", 8'hC0, LZ, LZ, LZ);
        runFrame("c1b", 8'hF9, 8'hF9, 8'hF9, 8'hF9);
        @(negedge i_clk);
        i_scan_clk = 1'b1;
        bc = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge i_clk);
            if (o_busy) bc++;
        end
        checkOutput("hold_com",  {12'd0, o_fnd_com}, 16'h000E);
        checkOutput("hold_font", {8'd0, o_fnd_font}, 16'h00F9);
        checkOutput("hold_busy", 16'(bc), 16'd15);
        i_scan_clk = 1'b0;
        repeat (20) @(negedge i_clk);
        checkOutput("fall_com",  {12'd0, o_fnd_com}, 16'h000E);
        applyStimulus(bc);
        checkOutput("d1_com",  {12'd0, o_fnd_com}, 16'h000D);
        checkOutput("d1_font", {8'd0, o_fnd_font}, 16'h00F9);
        i_value = 14'd2222;
        applyStimulus(bc);
        checkOutput("d2_font", {8'd0, o_fnd_font}, 16'h00F9);
        applyStimulus(bc);
        checkOutput("d3_font", {8'd0, o_fnd_font}, 16'h00F9);
        checkOutput("d3_com",  {12'd0, o_fnd_com}, 16'h0007);
        runFrame("c2a", 8'hF9, 8'hF9, 8'hF9, 8'hF9);
        runFrame("c2b", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

        // Reset during the 5th SHIFT cycle
        i_value = 14'd1234;
        @(negedge i_clk);
        i_scan_clk = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            if (o_busy) seen = 1'b1;
        end
        checkOutput("mid_busy_seen", {15'd0, seen}, 16'h0001);
        repeat (4) @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        checkOutput("mid_busy", {15'd0, o_busy},     16'h0000);
        checkOutput("mid_com",  {12'd0, o_fnd_com},  16'h000F);
        checkOutput("mid_font", {8'd0, o_fnd_font},  16'h00FF);
        i_scan_clk = 1'b0;
        repeat (5) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        runFrame("mid_a", 8'hC0, LZ, LZ, LZ);
        runFrame("mid_b", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
